// File: rtl/stream_pkt_arbiter.sv
// Packet-level round-robin arbiter: merges NUM_PORTS valid/ready/last streams into one,
// holding each grant for a whole packet and tagging every output beat with its source port.
module stream_pkt_arbiter #(
  parameter int  NUM_PORTS  = 4,
  parameter int  DATA_WIDTH = 8,
  localparam int ID_WIDTH   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_PORTS-1:0]            s_last,
  input  logic [NUM_PORTS-1:0]            s_valid,
  output logic [NUM_PORTS-1:0]            s_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_last,
  output logic [ID_WIDTH-1:0]             m_id,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] grant;
  logic [ID_WIDTH-1:0] last_grant;
  logic [ID_WIDTH-1:0] next_grant;
  logic [ID_WIDTH-1:0] cand;
  logic                found;

  // Search starts just after the previous winner, so it ranks lowest; the modulo
  // keeps non-power-of-2 port counts from ever producing an out-of-range index.
  always_comb begin
    next_grant = '0;
    cand       = '0;
    found      = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = ID_WIDTH'((int'(last_grant) + k) % NUM_PORTS);
      if (!found && s_valid[cand]) begin
        next_grant = cand;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    s_ready = '0;
    m_data  = '0;
    m_last  = 1'b0;
    m_id    = '0;
    m_valid = 1'b0;
    busy    = (state == BUSY);
    if (state == BUSY) begin
      s_ready[grant] = m_ready;
      m_data         = s_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      m_last         = s_last[grant];
      m_valid        = s_valid[grant];
      m_id           = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= ID_WIDTH'(NUM_PORTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|s_valid) begin
            grant <= next_grant;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (m_valid && m_ready && m_last) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Bench for stream_pkt_arbiter: per-port source queues drive a 4-port instance, a scoreboard
// holds the beats expected on the merged output; a 3-port instance covers odd port counts.
module tb_stream_pkt_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic [3:0]  s_last, s_valid, s_ready;
  logic [7:0]  m_data;
  logic        m_last, m_valid, m_ready, busy;
  logic [1:0]  m_id;

  logic [23:0] t_data;
  logic [2:0]  t_last, t_valid, t_ready;
  logic [7:0]  u_data;
  logic        u_last, u_valid, u_busy;
  logic        u_ready = 1'b1;
  logic [1:0]  u_id;

  stream_pkt_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_last(s_last), .s_valid(s_valid),
    .s_ready(s_ready), .m_data(m_data), .m_last(m_last), .m_id(m_id),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
  );

  stream_pkt_arbiter #(.NUM_PORTS(3), .DATA_WIDTH(8)) u_dut3 (
    .clk(clk), .rst(rst), .s_data(t_data), .s_last(t_last), .s_valid(t_valid),
    .s_ready(t_ready), .m_data(u_data), .m_last(u_last), .m_id(u_id),
    .m_valid(u_valid), .m_ready(u_ready), .busy(u_busy)
  );

  always #5 clk = ~clk;

  logic [8:0]  src_q [4][$];
  logic [10:0] exp_q [$];
  logic [1:0]  exp3 [$];
  int          last_cyc [$];
  int          sent [4];
  int          gap_after [4] = '{default: -1};
  int          gap_len [4];
  int          gap_cnt [4];
  int          cnt3 [3];
  logic [3:0]  xfer_seen = '0;
  logic [2:0]  x3 = '0;
  logic        en3 = 1'b0;
  int          cyc = 0;
  int          stall_cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic send(input int p, input int n, input int base, input bit track);
    for (int i = 0; i < n; i++) begin
      logic [8:0] b;
      b = {i == n - 1, 8'(base + i)};
      src_q[p].push_back(b);
      if (track) exp_q.push_back({2'(p), b});
    end
  endtask

  function automatic bit src_pending();
    src_pending = 1'b0;
    for (int p = 0; p < 4; p++) if (src_q[p].size() != 0) src_pending = 1'b1;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_pending()) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Source side: a beat leaves its queue once the previous negedge saw valid & ready.
  initial begin
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++) begin
        if (xfer_seen[p]) begin
          void'(src_q[p].pop_front());
          sent[p]++;
          if (sent[p] == gap_after[p]) gap_cnt[p] = gap_len[p];
        end
        if (gap_cnt[p] > 0) begin
          s_valid[p] = 1'b0;
          gap_cnt[p]--;
        end else begin
          s_valid[p] = (src_q[p].size() != 0);
        end
        if (src_q[p].size() != 0) {s_last[p], s_data[p*8 +: 8]} = src_q[p][0];
        else begin
          s_last[p]        = 1'b0;
          s_data[p*8 +: 8] = '0;
        end
      end
    end
  end

  // 3-port sources: ports 0 and 2 request continuously with 2-beat packets.
  initial begin
    t_valid = '0;
    t_last  = '0;
    t_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 3; p += 2) begin
        if (x3[p]) cnt3[p]++;
        t_valid[p]       = en3;
        t_last[p]        = (cnt3[p] % 2 == 1);
        t_data[p*8 +: 8] = 8'(p * 16 + (cnt3[p] & 15));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    xfer_seen = rst ? 4'b0 : (s_valid & s_ready);
    x3        = rst ? 3'b0 : (t_valid & t_ready);
    if (!rst) begin
      chk("s_ready", s_ready, busy ? (32'(m_ready) << m_id) : 32'd0);
      if (!busy) chk("idle_m_valid", m_valid, 0);
      if (busy && !m_valid) stall_cyc++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {m_id, m_last, m_data}, 32'hFFFF_FFFF);
        else chk("beat", {m_id, m_last, m_data}, exp_q.pop_front());
        if (m_last) last_cyc.push_back(cyc);
      end
      if (u_valid) begin
        chk("t5_id_range", u_id < 2'd3, 1);
        chk("t5_data_port", u_data[7:4], u_id);
        if (u_last && exp3.size() != 0) chk("t5_grant", u_id, exp3.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int s1;
    int st0;
    rst     = 1'b1;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_id", m_id, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);

    // All four ports request at once: service order 0,1,2,3, four cycles per packet.
    last_cyc.delete();
    for (int p = 0; p < 4; p++) send(p, 3, 8'h10 + p * 16, 1'b1);
    drain(200);
    chk("t1_npkts", last_cyc.size(), 4);
    for (int i = 1; i < last_cyc.size(); i++) chk("t1_spacing", last_cyc[i] - last_cyc[i-1], 4);

    // Port 2 alone, packets of 1, 2, 5 beats back to back.
    last_cyc.delete();
    send(2, 1, 8'h80, 1'b1);
    send(2, 2, 8'h90, 1'b1);
    send(2, 5, 8'hA0, 1'b1);
    drain(200);
    chk("t2_npkts", last_cyc.size(), 3);
    if (last_cyc.size() == 3) begin
      chk("t2_spacing_a", last_cyc[1] - last_cyc[0], 3);
      chk("t2_spacing_b", last_cyc[2] - last_cyc[1], 6);
    end

    // Port 1 stalls 3 cycles after beat 2 while port 0 waits.
    gap_after[1] = sent[1] + 2;
    gap_len[1]   = 3;
    st0          = stall_cyc;
    send(1, 4, 8'hC0, 1'b1);
    n = 0;
    while (!(busy && m_id == 2'd1) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t3_grant1", {busy, m_id}, {1'b1, 2'd1});
    send(0, 2, 8'hD0, 1'b1);
    drain(200);
    chk("t3_stall_cycles", stall_cyc - st0, 3);
    gap_after[1] = -1;

    // m_ready toggles every cycle during a 4-beat packet from port 3.
    send(3, 4, 8'hE0, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #2 m_ready = ~m_ready;
      n++;
    end
    m_ready = 1'b1;
    drain(100);
    chk("t4_src3_empty", src_q[3].size(), 0);
    send(0, 2, 8'h30, 1'b1);
    send(3, 2, 8'h40, 1'b1);
    drain(100);

    // Reset on beat 2 of a 5-beat packet from port 1.
    s1 = sent[1];
    send(1, 5, 8'h50, 1'b0);
    exp_q.push_back({2'd1, 1'b0, 8'h50});
    n = 0;
    while (sent[1] != s1 + 1 && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("t6_beat1_sent", sent[1] - s1, 1);
    rst = 1'b1;
    @(posedge clk);
    #2 src_q[1].delete();
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_m_valid", m_valid, 0);
    chk("t6_s_ready", s_ready, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    chk("t6_exp_empty", exp_q.size(), 0);
    send(0, 2, 8'h60, 1'b1);
    send(1, 2, 8'h70, 1'b1);
    drain(100);

    // 3-port instance: ports 0 and 2 alternate.
    exp3 = '{2'd0, 2'd2, 2'd0, 2'd2};
    en3  = 1'b1;
    n = 0;
    while (exp3.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t5_grants_left", exp3.size(), 0);
    en3 = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_pkt_arbiter.md
Name: stream_pkt_arbiter

Overview:
Packet-level round-robin arbiter that merges NUM_PORTS valid/ready/last input streams into one output stream.
- Typically feeds a stream_fifo write port, or shares one downstream FIFO between several producers.
- A grant is held for a whole packet, so beats of different packets never interleave on the output.
- The granted port index travels with each beat on m_id.

Parameters:
NUM_PORTS, 4, number of requesting input streams (2..16).
DATA_WIDTH, 8, data width per beat.
ID_WIDTH (localparam), max(1, $clog2(NUM_PORTS)), width of the port index.

Ports:
clk  in  1  clock; single clock domain.
rst  in  1  synchronous, active-high reset.
s_data  in  NUM_PORTS*DATA_WIDTH  input data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
s_last  in  NUM_PORTS  per-port end-of-packet flag.
s_valid  in  NUM_PORTS  per-port valid.
s_ready  out  NUM_PORTS  per-port ready.
m_data  out  DATA_WIDTH  merged output data.
m_last  out  1  output end-of-packet flag.
m_id  out  ID_WIDTH  index of the port whose beat is on the output.
m_valid  out  1  output valid.
m_ready  in  1  output ready.
busy  out  1  high while a grant is held (state BUSY).

Behaviour:
- A beat transfers on any stream when valid & ready are both high at posedge clk.
- Registered state:
  - state ∈ {IDLE, BUSY}
  - grant (ID_WIDTH)
  - last_grant (ID_WIDTH)
- Reset (rst high at posedge), effective the next cycle:
  - state = IDLE, grant = 0, last_grant = NUM_PORTS-1, so port 0 has first priority.
  - Outputs: s_ready = 0, m_valid = 0, busy = 0, m_id = 0, m_last = 0, m_data = 0.
- IDLE:
  - All s_ready = 0; m_valid = 0; m_data, m_last, m_id = 0.
  - If any s_valid bit is set: grant <= first port with s_valid set, searching last_grant+1, last_grant+2, … modulo NUM_PORTS; state <= BUSY.
  - Otherwise remain in IDLE.
- BUSY (combinational pass-through, zero added latency):
  - m_data = s_data[grant], m_last = s_last[grant], m_valid = s_valid[grant], m_id = grant.
  - s_ready[grant] = m_ready; all other s_ready bits = 0.
  - busy = 1.
- Leaving BUSY:
  - On a transfer with m_last = 1: last_grant <= grant; state <= IDLE.
  - Any other case (no transfer, or transfer with m_last = 0): stay in BUSY with the same grant.
- Per-packet cost: one arbitration bubble cycle (IDLE) between consecutive packets.
  - Throughput for back-to-back N-beat packets is N/(N+1).
- Requester stalls mid-packet (s_valid[grant] low): grant is held and m_valid = 0. Other ports stay blocked until the granted port's last beat.
- Modulo search: wrap-around from NUM_PORTS-1 to 0 is exact. Non-power-of-2 NUM_PORTS must never select an index ≥ NUM_PORTS.
- Simultaneous events:
  - A request that appears in the same cycle the last beat transfers is evaluated in the following IDLE cycle.
  - A port that just finished is lowest priority in that evaluation.
- Single-beat packet: s_last = 1 on the first beat; the packet occupies exactly 2 cycles (IDLE + BUSY) when m_ready = 1.
- Deassertion after the grant: s_valid of non-granted ports may drop at any time with no effect. s_data and s_last of the granted port must be held stable while s_valid is high and s_ready is low (AXI-Stream rule, relied upon, not checked).
- Reset mid-packet: the arbiter returns to IDLE and the remainder of the packet is abandoned. Downstream must be reset together with the arbiter.
- Starvation bound: a continuously requesting port is granted within NUM_PORTS-1 packets of other ports.

Test Plan:
1. Reset, then s_valid=4'b1111, each port sends a 3-beat packet, m_ready=1 → m_id order 0,1,2,3; each packet occupies 4 cycles (1 idle + 3 beats); m_data matches each port's sequence.
2. Port 2 alone sends packets of 1, 2, 5 beats back to back → m_id=2 for all beats; one m_valid=0 cycle between packets; s_ready=4'b0100 only in BUSY.
3. Grant port 1 with a 4-beat packet; port 1 drops s_valid for 3 cycles after beat 2 while port 0 requests → m_valid=0 during the gap; s_ready[0]=0 throughout; beats 3–4 follow from port 1, then port 0 is granted.
4. m_ready toggles 1,0,1,0 during a 4-beat packet from port 3 → exactly 4 transfers, no beat duplicated or lost; s_ready[3] follows m_ready; last_grant=3 afterwards, so the next request from port 0 wins over port 3.
5. NUM_PORTS=3, ports 2 and 0 request continuously → grants alternate 0,2,0,2; m_id never equals 3.
6. rst asserted on beat 2 of a 5-beat packet from port 1 → the next cycle shows busy=0, m_valid=0, s_ready=0; the first grant after reset with s_valid=3'b011 goes to port 0.
